// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - RV32I ALU-class decode with a single registered valid/ready stage
module alu_dispatch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [4:0]  shamt,
  output logic        sub_sra,
  output logic [3:0]  func,
  output logic [4:0]  rd,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        accept;

  logic [31:0] d_a;
  logic [31:0] d_b;
  logic [4:0]  d_shamt;
  logic        d_sub;
  logic [3:0]  d_func;
  logic        d_ill;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Reset forces ready high but never lets a beat in during the reset cycle.
  assign in_ready = !out_valid || out_ready || !rst_n;
  assign accept   = in_valid && in_ready && rst_n;

  always_comb begin
    d_a     = '0;
    d_b     = '0;
    d_shamt = '0;
    d_sub   = 1'b0;
    d_func  = 4'b0000;
    d_ill   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if ((f7 != F7_BASE && f7 != F7_ALT) ||
            (f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101)) begin
          d_ill = 1'b1;
        end else begin
          d_a = rs1_data;
          d_b = rs2_data;
          case (f3)
            3'b000:  d_func = 4'b0000;
            3'b001:  d_func = 4'b0101;
            3'b010:  d_func = 4'b1000;
            3'b011:  d_func = 4'b1001;
            3'b100:  d_func = 4'b0001;
            3'b101:  d_func = 4'b0110;
            3'b110:  d_func = 4'b0010;
            default: d_func = 4'b0011;
          endcase
          if (f3 == 3'b000 || f3 == 3'b101) d_sub = instr[30];
          // Register shifts only honour the low five bits of rs2.
          if (f3 == 3'b001 || f3 == 3'b101) d_b = {27'b0, rs2_data[4:0]};
        end
      end
      OPC_OP_IMM: begin
        if ((f3 == 3'b001 && f7 != F7_BASE) ||
            (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT)) begin
          d_ill = 1'b1;
        end else begin
          d_a = rs1_data;
          d_b = {{20{instr[31]}}, instr[31:20]};
          case (f3)
            3'b000:  d_func = 4'b0000;
            3'b001:  d_func = 4'b0100;
            3'b010:  d_func = 4'b1000;
            3'b011:  d_func = 4'b1001;
            3'b100:  d_func = 4'b0001;
            3'b101:  d_func = 4'b0111;
            3'b110:  d_func = 4'b0010;
            default: d_func = 4'b0011;
          endcase
          if (f3 == 3'b001 || f3 == 3'b101) d_shamt = instr[24:20];
          if (f3 == 3'b101) d_sub = instr[30];
        end
      end
      OPC_LUI: begin
        d_b = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        d_a = pc;
        d_b = {instr[31:12], 12'b0};
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      shamt     <= '0;
      sub_sra   <= 1'b0;
      func      <= 4'b0000;
      rd        <= '0;
      illegal   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        A         <= d_a;
        B         <= d_b;
        shamt     <= d_shamt;
        sub_sra   <= d_sub;
        func      <= d_func;
        rd        <= instr[11:7];
        illegal   <= d_ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - directed self-checking bench for alu_dispatch
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        sub_sra;
  logic [3:0]  func;
  logic [4:0]  rd;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_dispatch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .A        (A),
    .B        (B),
    .shamt    (shamt),
    .sub_sra  (sub_sra),
    .func     (func),
    .rd       (rd),
    .illegal  (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic ill, input logic [31:0] ea,
                            input logic [31:0] eb, input logic [4:0] esh, input logic esub,
                            input logic [3:0] efn, input logic [4:0] erd);
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".illegal"}, {31'b0, illegal}, {31'b0, ill});
    check({tag, ".A"}, A, ea);
    check({tag, ".B"}, B, eb);
    check({tag, ".shamt"}, {27'b0, shamt}, {27'b0, esh});
    check({tag, ".sub_sra"}, {31'b0, sub_sra}, {31'b0, esub});
    check({tag, ".func"}, {28'b0, func}, {28'b0, efn});
    check({tag, ".rd"}, {27'b0, rd}, {27'b0, erd});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".illegal"}, {31'b0, illegal}, 32'd0);
    check({tag, ".A"}, A, 32'd0);
    check({tag, ".B"}, B, 32'd0);
    check({tag, ".shamt"}, {27'b0, shamt}, 32'd0);
    check({tag, ".sub_sra"}, {31'b0, sub_sra}, 32'd0);
    check({tag, ".func"}, {28'b0, func}, 32'd0);
    check({tag, ".rd"}, {27'b0, rd}, 32'd0);
  endtask

  // Present one beat with out_ready=1, accept it and leave the bench #1 after the edge.
  task automatic issue(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    instr = i; pc = p; rs1_data = r1; rs2_data = r2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    instr = 32'h002081B3; pc = 32'h0; rs1_data = 32'd5; rs2_data = 32'd7;

    // Reset, with a beat offered during the reset cycle
    @(posedge clk); #1;
    check_zero("reset");
    check("reset.in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b1;
    check("post_reset.in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("post_reset.out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;

    // ADD x3,x1,x2
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
    check_beat("add", 1'b0, 32'd5, 32'd7, 5'd0, 1'b0, 4'b0000, 5'd3);
    @(posedge clk); #1;
    check("drain.out_valid", {31'b0, out_valid}, 32'd0);

    // SRAI x4,x1,31: instr[31]=0 so the immediate sign-extends to 0x0000041F
    issue(32'h41F0D213, 32'h0, 32'h80000000, 32'h0);
    check_beat("srai", 1'b0, 32'h80000000, 32'h0000041F, 5'd31, 1'b1, 4'b0111, 5'd4);

    // Back-to-back beats with no bubble
    issue(32'h00209333, 32'h0, 32'd3, 32'h00000021);
    check_beat("sll", 1'b0, 32'd3, 32'd1, 5'd0, 1'b0, 4'b0101, 5'd6);
    issue(32'h402081B3, 32'h0, 32'd9, 32'd4);
    check_beat("sub", 1'b0, 32'd9, 32'd4, 5'd0, 1'b1, 4'b0000, 5'd3);
    issue(32'h4020D3B3, 32'h0, 32'hF0000000, 32'hFFFFFFE3);
    check_beat("sra", 1'b0, 32'hF0000000, 32'd3, 5'd0, 1'b1, 4'b0110, 5'd7);
    issue(32'h0020A433, 32'h0, 32'd1, 32'd2);
    check_beat("slt", 1'b0, 32'd1, 32'd2, 5'd0, 1'b0, 4'b1000, 5'd8);
    issue(32'hFFF08493, 32'h0, 32'h10, 32'h0);
    check_beat("addi_neg", 1'b0, 32'h10, 32'hFFFFFFFF, 5'd0, 1'b0, 4'b0000, 5'd9);
    issue(32'h00509513, 32'h0, 32'h1, 32'h0);
    check_beat("slli", 1'b0, 32'h1, 32'd5, 5'd5, 1'b0, 4'b0100, 5'd10);
    issue(32'hFFFFF0B7, 32'h0, 32'h55, 32'h66);
    check_beat("lui", 1'b0, 32'h0, 32'hFFFFF000, 5'd0, 1'b0, 4'b0000, 5'd1);

    // Illegal encodings still handshake with zeroed payload
    issue(32'h40509513, 32'h0, 32'h1, 32'h2);
    check_beat("ill_slli_f7", 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 4'b0000, 5'd10);
    issue(32'h4020C1B3, 32'h0, 32'h1, 32'h2);
    check_beat("ill_xor_alt", 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 4'b0000, 5'd3);
    issue(32'h02000033, 32'h0, 32'h1, 32'h2);
    check_beat("ill_f7", 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 4'b0000, 5'd0);
    issue(32'h0000007F, 32'h0, 32'h1, 32'h2);
    check_beat("ill_opc", 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 4'b0000, 5'd0);
    issue(32'h12345297, 32'h100, 32'h1, 32'h2);
    check_beat("auipc", 1'b0, 32'h100, 32'h12345000, 5'd0, 1'b0, 4'b0000, 5'd5);
    @(posedge clk); #1;

    // Stall: downstream holds off for three cycles while a new beat waits
    out_ready = 1'b0;
    check("empty_stall.in_ready", {31'b0, in_ready}, 32'd1);
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
    instr = 32'h402081B3; rs1_data = 32'd20; rs2_data = 32'd6; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("stall.in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check_beat("stall_hold", 1'b0, 32'd5, 32'd7, 5'd0, 1'b0, 4'b0000, 5'd3);
    end
    out_ready = 1'b1; #1;
    check("release.in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check_beat("release_load", 1'b0, 32'd20, 32'd6, 5'd0, 1'b1, 4'b0000, 5'd3);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("release_drain.out_valid", {31'b0, out_valid}, 32'd0);

    // Reset while full and stalled, with a beat offered in the reset cycle
    out_ready = 1'b0;
    issue(32'h00209333, 32'h0, 32'd3, 32'h00000021);
    check("pre_reset.in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0; in_valid = 1'b1; instr = 32'h002081B3; #1;
    check("mid_reset.in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check_zero("mid_reset");
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("after_reset.out_valid", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
